// File: rtl/dma_bus_arbiter_if.sv
// rtl/dma_bus_arbiter_if.sv - CPU/DMA bus-ownership handshake signals
interface dma_bus_arbiter_if;
    logic [2:0] s_n;
    logic       lock_n;
    logic       hrq;
    logic       holda;
    logic       cpu_aen_n;
    logic       dma_aen;
    logic       cpu_wait;
    logic       dma_timeout;
    logic       busy;

    modport slave (
        input  s_n, lock_n, hrq,
        output holda, cpu_aen_n, dma_aen, cpu_wait, dma_timeout, busy
    );

    modport master (
        output s_n, lock_n, hrq,
        input  holda, cpu_aen_n, dma_aen, cpu_wait, dma_timeout, busy
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - hands the system bus between the 8088 and the 8237 with guard gaps
module dma_bus_arbiter #(
    parameter int unsigned GUARD     = 2,
    parameter int unsigned MAX_GRANT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dma_bus_arbiter_if.slave      bus
);
    typedef enum logic [2:0] {IDLE, DRAIN, DISABLE, GRANT, RELEASE} state_e;

    localparam logic [3:0]  GUARD_W = 4'(GUARD);
    localparam logic [15:0] MAX_W   = 16'(MAX_GRANT);

    state_e      state_q, state_d;
    logic [3:0]  guard_q, guard_d, guard_dec;
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic        timeout_q, timeout_d;
    logic        holda_q, dma_aen_q, cpu_aen_n_q, cpu_wait_q, busy_q;
    logic        passive;

    assign passive   = (bus.s_n == 3'b111);
    assign guard_dec = guard_q - 4'd1;

    // Guard is loaded on entry so a state lasts exactly GUARD clocks.
    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        grant_cnt_d = grant_cnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.hrq && bus.lock_n) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.hrq) begin
                    state_d = IDLE;
                end else if (passive) begin
                    state_d = DISABLE;
                    guard_d = GUARD_W;
                end
            end
            DISABLE: begin
                guard_d = guard_dec;
                if (guard_dec == 4'd0) begin
                    if (bus.hrq) begin
                        state_d     = GRANT;
                        grant_cnt_d = 16'd0;
                    end else begin
                        state_d = RELEASE;
                        guard_d = GUARD_W;
                    end
                end
            end
            GRANT: begin
                if (grant_cnt_q != 16'hFFFF) grant_cnt_d = grant_cnt_q + 16'd1;
                if (grant_cnt_d == MAX_W) timeout_d = 1'b1;
                if (!bus.hrq) begin
                    state_d = RELEASE;
                    guard_d = GUARD_W;
                end
            end
            RELEASE: begin
                guard_d = guard_dec;
                if (guard_dec == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they stay registered yet track state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            guard_q     <= 4'd0;
            grant_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
            holda_q     <= 1'b0;
            dma_aen_q   <= 1'b0;
            cpu_aen_n_q <= 1'b0;
            cpu_wait_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            grant_cnt_q <= grant_cnt_d;
            timeout_q   <= timeout_d;
            holda_q     <= (state_d == GRANT);
            dma_aen_q   <= (state_d == GRANT);
            cpu_aen_n_q <= (state_d == DISABLE) || (state_d == GRANT) || (state_d == RELEASE);
            cpu_wait_q  <= (state_d != IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.holda       = holda_q;
    assign bus.dma_aen     = dma_aen_q;
    assign bus.cpu_aen_n   = cpu_aen_n_q;
    assign bus.cpu_wait    = cpu_wait_q;
    assign bus.dma_timeout = timeout_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - bench for dma_bus_arbiter
module tb_dma_bus_arbiter;
    localparam int GUARD     = 2;
    localparam int MAX_GRANT = 8;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    dma_bus_arbiter_if bus ();

    dma_bus_arbiter #(.GUARD(GUARD), .MAX_GRANT(MAX_GRANT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference: who is stalled, whether CPU commands are off, whether DMA holds the bus.
    bit m_stalled, m_cmd_off, m_dma_owns, m_returning, m_tmo;
    int m_gap_left, m_grant_len;

    task automatic model_reset();
        m_stalled = 0; m_cmd_off = 0; m_dma_owns = 0; m_returning = 0; m_tmo = 0;
        m_gap_left = 0; m_grant_len = 0;
    endtask

    task automatic model_edge(input bit h, input bit pas, input bit lk);
        if (m_dma_owns) begin
            if (m_grant_len < 65535) m_grant_len++;
            if (m_grant_len >= MAX_GRANT) m_tmo = 1;
            if (!h) begin
                m_dma_owns = 0; m_returning = 1; m_gap_left = GUARD;
            end
        end else if (m_cmd_off) begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                if (m_returning) begin
                    m_cmd_off = 0; m_stalled = 0; m_returning = 0;
                end else if (h) begin
                    m_dma_owns = 1; m_grant_len = 0;
                end else begin
                    m_returning = 1; m_gap_left = GUARD;
                end
            end
        end else if (m_stalled) begin
            if (!h) m_stalled = 0;
            else if (pas) begin
                m_cmd_off = 1; m_gap_left = GUARD;
            end
        end else if (h && lk) begin
            m_stalled = 1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".holda"},       16'(bus.holda),       16'(m_dma_owns));
        check({tag, ".dma_aen"},     16'(bus.dma_aen),     16'(m_dma_owns));
        check({tag, ".cpu_aen_n"},   16'(bus.cpu_aen_n),   16'(m_cmd_off));
        check({tag, ".cpu_wait"},    16'(bus.cpu_wait),    16'(m_stalled));
        check({tag, ".busy"},        16'(bus.busy),        16'(m_stalled));
        check({tag, ".dma_timeout"}, 16'(bus.dma_timeout), 16'(m_tmo));
    endtask

    task automatic step(input string tag);
        bit h, p, l;
        h = bus.hrq;
        p = (bus.s_n == 3'b111);
        l = bus.lock_n;
        @(posedge clk_i);
        #1;
        model_edge(h, p, l);
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk_i);
        #1;
        check_all("rst_held");
        rst_i = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_i   = 1'b0;
        bus.s_n    = 3'b111;
        bus.lock_n = 1'b1;
        bus.hrq    = 1'b0;
        model_reset();
        #2 rst_i = 1'b1;
        #1;
        check_all("por");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step("idle");

        // Basic grant with an already-passive CPU.
        bus.hrq = 1'b1;
        step("bg1");
        check("bg1.cpu_wait", 16'(bus.cpu_wait), 16'd1);
        check("bg1.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd0);
        step("bg2");
        check("bg2.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd1);
        check("bg2.holda", 16'(bus.holda), 16'd0);
        step("bg3");
        check("bg3.holda", 16'(bus.holda), 16'd0);
        step("bg4");
        check("bg4.holda", 16'(bus.holda), 16'd1);
        check("bg4.dma_aen", 16'(bus.dma_aen), 16'd1);
        for (int i = 5; i <= 10; i++) step("bg_grant");
        bus.hrq = 1'b0;
        step("bg11");
        check("bg11.holda", 16'(bus.holda), 16'd0);
        check("bg11.cpu_wait", 16'(bus.cpu_wait), 16'd1);
        step("bg12");
        check("bg12.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd1);
        step("bg13");
        check("bg13.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd0);
        check("bg13.cpu_wait", 16'(bus.cpu_wait), 16'd0);
        check("bg13.timeout", 16'(bus.dma_timeout), 16'd0);

        // CPU mid-cycle: DRAIN holds until status goes passive.
        bus.s_n = 3'b100;
        bus.hrq = 1'b1;
        step("act1");
        for (int i = 0; i < 3; i++) begin
            step("act_drain");
            check("act.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd0);
        end
        bus.s_n = 3'b111;
        step("act_dis");
        check("act_dis.cpu_aen_n", 16'(bus.cpu_aen_n), 16'd1);
        step("act_g0");
        step("act_g1");
        check("act_g1.holda", 16'(bus.holda), 16'd1);
        bus.hrq = 1'b0;
        for (int i = 0; i < 3; i++) step("act_rel");

        // Locked sequence blocks the request.
        bus.lock_n = 1'b0;
        bus.hrq    = 1'b1;
        for (int i = 0; i < 20; i++) step("lock");
        check("lock.busy", 16'(bus.busy), 16'd0);
        bus.lock_n = 1'b1;
        step("unlock");
        check("unlock.busy", 16'(bus.busy), 16'd1);

        // Abort while CPU commands are disabled.
        step("ab_dis");
        bus.hrq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("abort");
            check("abort.holda", 16'(bus.holda), 16'd0);
        end
        check("abort.busy", 16'(bus.busy), 16'd0);

        // One-clock request pulse.
        bus.hrq = 1'b1;
        step("pulse_hi");
        bus.hrq = 1'b0;
        step("pulse_lo");
        check("pulse.busy", 16'(bus.busy), 16'd0);

        // Timeout after MAX_GRANT grant clocks; sticky until reset.
        bus.hrq = 1'b1;
        for (int i = 0; i < 4; i++) step("to_setup");
        for (int i = 0; i < 7; i++) step("to_grant");
        check("to7.timeout", 16'(bus.dma_timeout), 16'd0);
        step("to8");
        check("to8.timeout", 16'(bus.dma_timeout), 16'd1);
        for (int i = 0; i < 4; i++) step("to_more");
        bus.hrq = 1'b0;
        for (int i = 0; i < 4; i++) step("to_rel");
        check("to_rel.timeout", 16'(bus.dma_timeout), 16'd1);
        check("to_rel.busy", 16'(bus.busy), 16'd0);
        do_reset();
        check("to_rst.timeout", 16'(bus.dma_timeout), 16'd0);

        // Reset in the middle of a grant: no guard gap.
        bus.hrq = 1'b1;
        for (int i = 0; i < 6; i++) step("mid_grant");
        check("mid.holda", 16'(bus.holda), 16'd1);
        do_reset();
        check("mid_rst.holda", 16'(bus.holda), 16'd0);
        check("mid_rst.cpu_wait", 16'(bus.cpu_wait), 16'd0);
        bus.hrq = 1'b0;
        step("post_rst");

        // Randomised traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) bus.hrq = ~bus.hrq;
            bus.s_n    = ($urandom_range(9) < 6) ? 3'b111 : 3'($urandom);
            bus.lock_n = ($urandom_range(9) != 0);
            if ($urandom_range(299) == 0) do_reset();
            else step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
